// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one fixed-latency, single-ported memory between the instruction-fetch
// and data-memory stages of the pipeline. Each access runs
// IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP. The owner's ack pulses in RESP.
// Data requests win arbitration. After MAX_STREAK consecutive data grants made
// while a fetch was waiting, the fetch is granted instead.

module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              if_stall,

  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              dm_stall,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy,
  output logic              gnt_dm
);

  localparam int CNT_W    = $clog2(MEM_LAT + 1);
  localparam int STREAK_W = $clog2(MAX_STREAK + 1);

  localparam logic [CNT_W-1:0]    LAT_LOAD   = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [CNT_W-1:0]    r_wait_cnt;
  logic [STREAK_W-1:0] r_streak;

  logic                r_gnt_dm;
  logic                r_we;
  logic                r_busy;
  logic                r_mem_en;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;

  logic                r_if_ack;
  logic                r_dm_ack;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_dm_rdata;

  logic                w_grant;
  logic                w_grant_dm;
  logic                w_fetch_turn;
  logic                w_wait_last;
  logic                w_done;

  // Next-state and grant decision; a grant is only ever made from IDLE.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant      = 1'b0;
    w_grant_dm   = 1'b0;
    w_fetch_turn = if_req && (r_streak == STREAK_MAX);
    w_wait_last  = (r_wait_cnt == CNT_ONE);
    w_done       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (if_req || dm_req) begin
          w_grant     = 1'b1;
          // Data has priority unless the fetch has been passed over MAX_STREAK times.
          w_grant_dm  = dm_req && !w_fetch_turn;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_wait_last) begin
          w_done      = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register, with busy registered alongside it so it is glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  // Memory-latency counter: loaded in ISSUE and counted down through WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_wait_cnt <= LAT_LOAD;
    end else if (r_state == S_WAIT) begin
      r_wait_cnt <= r_wait_cnt - CNT_ONE;
    end
  end

  // Fairness counter: counts data grants made while a fetch was waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_streak <= '0;
    end else if (w_grant) begin
      if (w_grant_dm && if_req) begin
        if (r_streak != STREAK_MAX) begin
          r_streak <= r_streak + STREAK_ONE;
        end
      end else begin
        r_streak <= '0;
      end
    end
  end

  // Latch the winning request. Write data only follows data grants, and a fetch is always a read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gnt_dm    <= 1'b0;
      r_we        <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_grant) begin
      r_gnt_dm   <= w_grant_dm;
      r_we       <= w_grant_dm && dm_we;
      r_mem_addr <= w_grant_dm ? dm_addr : if_addr;
      if (w_grant_dm) begin
        r_mem_wdata <= dm_wdata;
      end
    end
  end

  // Access strobes: high for exactly the ISSUE cycle that follows a grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
    end else begin
      r_mem_en <= w_grant;
      r_mem_we <= w_grant && w_grant_dm && dm_we;
    end
  end

  // Capture read data on the last WAIT cycle; the owner's ack and word appear in RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_if_ack   <= 1'b0;
      r_dm_ack   <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      r_if_ack <= w_done && !r_gnt_dm;
      r_dm_ack <= w_done && r_gnt_dm;
      if (w_done && !r_we) begin
        if (r_gnt_dm) begin
          r_dm_rdata <= mem_rdata;
        end else begin
          r_if_rdata <= mem_rdata;
        end
      end
    end
  end

  assign if_ack    = r_if_ack;
  assign dm_ack    = r_dm_ack;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;
  assign gnt_dm    = r_gnt_dm;

  // Stalls release in the ack cycle so the stage can advance on that edge.
  assign if_stall  = if_req && !r_if_ack;
  assign dm_stall  = dm_req && !r_dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter.
// Stimulus pushes the expected memory accesses and acknowledges into queues.
// Negedge monitors pop and compare each one when the DUT raises mem_en or an ack.
// Instance A uses MEM_LAT=2 and MAX_STREAK=4. Instance B uses MEM_LAT=1 for streaming fetches.

module tb_mem_port_arbiter;

  localparam logic [31:0] FILL = 32'h0BAD_0BAD;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } iss_t;

  typedef struct {
    int          cyc;
    logic        dm;
    logic [31:0] rdata;
  } ack_t;

  logic clk = 1'b0;
  logic reset;

  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ack, if_stall, dm_ack, dm_stall, mem_en, mem_we, busy, gnt_dm;

  logic        b_if_req, b_dm_req, b_dm_we;
  logic [31:0] b_if_addr, b_dm_addr, b_dm_wdata, b_mem_rdata;
  logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata;
  logic        b_if_ack, b_if_stall, b_dm_ack, b_dm_stall, b_mem_en, b_mem_we, b_busy, b_gnt_dm;

  iss_t q_iss_a[$];
  iss_t q_iss_b[$];
  ack_t q_ack_a[$];
  ack_t q_ack_b[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int          pend_cyc_a  = -1;
  int          pend_cyc_b  = -1;
  logic [31:0] pend_word_a = '0;
  logic [31:0] pend_word_b = '0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .MAX_STREAK(4)) u_dut_a (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .gnt_dm(gnt_dm)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_STREAK(4)) u_dut_b (
    .clk(clk), .reset(reset),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack), .if_stall(b_if_stall),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_rdata(b_dm_rdata), .dm_ack(b_dm_ack), .dm_stall(b_dm_stall),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy), .gnt_dm(b_gnt_dm)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Word the memory returns for a read of address a.
  function automatic logic [31:0] resp_word(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEAD_BEEF : {~a[15:0], a[15:0]};
  endfunction

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic mon_iss(input int id, input logic en, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    iss_t e;
    int   have;
    if (!en) begin
      check32($sformatf("stray_mem_we_%0d", id), 32'(we), 32'd0);
    end else begin
      have = (id == 0) ? q_iss_a.size() : q_iss_b.size();
      n_cmp++;
      if (have == 0) begin
        n_bad++;
        $display("FAIL iss_%0d unexpected mem_en at cycle %0d addr %h we %0b, expected no access",
                 id, cyc, addr, we);
      end else begin
        if (id == 0) e = q_iss_a.pop_front();
        else         e = q_iss_b.pop_front();
        if (cyc != e.cyc || addr !== e.addr || we !== e.we || (e.we && wdata !== e.wdata)) begin
          n_bad++;
          $display("FAIL iss_%0d: got cyc %0d addr %h we %0b wdata %h, expected cyc %0d addr %h we %0b wdata %h",
                   id, cyc, addr, we, wdata, e.cyc, e.addr, e.we, e.wdata);
        end
      end
      if (!we) begin
        if (id == 0) begin pend_cyc_a = cyc + 2; pend_word_a = resp_word(addr); end
        else         begin pend_cyc_b = cyc + 1; pend_word_b = resp_word(addr); end
      end
    end
  endtask

  task automatic mon_ack(input int id, input logic ia, input logic da,
                         input logic [31:0] ird, input logic [31:0] drd);
    ack_t        e;
    int          have;
    logic [31:0] got;
    if (ia || da) begin
      have = (id == 0) ? q_ack_a.size() : q_ack_b.size();
      n_cmp++;
      if (have == 0) begin
        n_bad++;
        $display("FAIL ack_%0d unexpected at cycle %0d: if_ack %0b dm_ack %0b, expected none", id, cyc, ia, da);
      end else begin
        if (id == 0) e = q_ack_a.pop_front();
        else         e = q_ack_b.pop_front();
        got = e.dm ? drd : ird;
        if (cyc != e.cyc || da !== e.dm || ia !== !e.dm || got !== e.rdata) begin
          n_bad++;
          $display("FAIL ack_%0d: got cyc %0d if_ack %0b dm_ack %0b rdata %h, expected cyc %0d dm %0b rdata %h",
                   id, cyc, ia, da, got, e.cyc, e.dm, e.rdata);
        end
      end
    end
  endtask

  // Scoreboard monitors.
  always @(negedge clk) begin
    if (reset) begin
      mon_iss(0, mem_en, mem_we, mem_addr, mem_wdata);
      mon_ack(0, if_ack, dm_ack, if_rdata, dm_rdata);
      mon_iss(1, b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata);
      mon_ack(1, b_if_ack, b_dm_ack, b_if_rdata, b_dm_rdata);
    end
  end

  // Memory models: drive read data only in the cycle it is due, filler otherwise.
  initial begin
    mem_rdata   = FILL;
    b_mem_rdata = FILL;
    forever begin
      @(posedge clk);
      #1;
      mem_rdata   = (cyc == pend_cyc_a) ? pend_word_a : FILL;
      b_mem_rdata = (cyc == pend_cyc_b) ? pend_word_b : FILL;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic push_iss_a(input int c, input logic [31:0] a, input logic we, input logic [31:0] wd);
    iss_t e;
    e.cyc = c; e.addr = a; e.we = we; e.wdata = wd;
    q_iss_a.push_back(e);
  endtask

  task automatic push_ack_a(input int c, input logic dm, input logic [31:0] rd);
    ack_t e;
    e.cyc = c; e.dm = dm; e.rdata = rd;
    q_ack_a.push_back(e);
  endtask

  task automatic push_iss_b(input int c, input logic [31:0] a);
    iss_t e;
    e.cyc = c; e.addr = a; e.we = 1'b0; e.wdata = '0;
    q_iss_b.push_back(e);
  endtask

  task automatic push_ack_b(input int c, input logic [31:0] rd);
    ack_t e;
    e.cyc = c; e.dm = 1'b0; e.rdata = rd;
    q_ack_b.push_back(e);
  endtask

  task automatic check_zero_a(input string nm);
    check32({nm, "_ctl"}, 32'({if_ack, dm_ack, mem_en, mem_we, busy, gnt_dm}), 32'd0);
    check32({nm, "_mem_addr"}, mem_addr, 32'd0);
    check32({nm, "_mem_wdata"}, mem_wdata, 32'd0);
    check32({nm, "_if_rdata"}, if_rdata, 32'd0);
    check32({nm, "_dm_rdata"}, dm_rdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset = 1'b0;
    if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
    if_addr = 32'h44; dm_addr = 32'h88; dm_wdata = 32'h99;
    b_if_req = 1'b1; b_dm_req = 1'b0; b_dm_we = 1'b0;
    b_if_addr = '0; b_dm_addr = '0; b_dm_wdata = '0;

    // Reset held with both requests pending.
    repeat (3) begin
      @(negedge clk);
      check_zero_a("rst");
      check32("rst_b_ctl", 32'({b_if_ack, b_mem_en, b_busy}), 32'd0);
    end
    if_req = 1'b0; dm_req = 1'b0; b_if_req = 1'b0;
    step();
    reset = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check32("idle_after_rst", 32'({mem_en, busy}), 32'd0);
    end

    // Single fetch.
    step();
    t = cyc;
    if_addr = 32'h40; if_req = 1'b1;
    push_iss_a(t + 1, 32'h40, 1'b0, 32'h0);
    push_ack_a(t + 4, 1'b0, 32'hDEAD_BEEF);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      check32($sformatf("fetch_if_stall_T+%0d", k), 32'(if_stall), (k < 4) ? 32'd1 : 32'd0);
      step();
    end
    if_req = 1'b0;

    // Reset during WAIT of a data read, request held through it.
    step();
    t = cyc;
    dm_addr = 32'h200; dm_we = 1'b0; dm_req = 1'b1;
    push_iss_a(t + 1, 32'h200, 1'b0, 32'h0);
    goto(t + 2);
    reset = 1'b0;
    #1;
    check_zero_a("midwait_rst");
    goto(t + 4);
    reset = 1'b1;
    push_iss_a(t + 5, 32'h200, 1'b0, 32'h0);
    push_ack_a(t + 8, 1'b1, 32'hFDFF_0200);
    goto(t + 9);
    dm_req = 1'b0;

    // Collision: data write beats the fetch, then the fetch runs.
    step();
    t = cyc;
    if_addr = 32'h0; if_req = 1'b1;
    dm_addr = 32'h100; dm_we = 1'b1; dm_wdata = 32'h55; dm_req = 1'b1;
    push_iss_a(t + 1, 32'h100, 1'b1, 32'h55);
    push_ack_a(t + 4, 1'b1, 32'hFDFF_0200);
    push_iss_a(t + 6, 32'h0, 1'b0, 32'h0);
    push_ack_a(t + 9, 1'b0, 32'hFFFF_0000);
    goto(t + 1);
    @(negedge clk);
    check32("coll_busy_gnt_dm", 32'({busy, gnt_dm}), 32'd3);
    check32("coll_stalls", 32'({if_stall, dm_stall}), 32'd3);
    goto(t + 4);
    @(negedge clk);
    check32("coll_dm_stall_ack", 32'(dm_stall), 32'd0);
    goto(t + 5);
    dm_req = 1'b0; dm_we = 1'b0;
    goto(t + 6);
    @(negedge clk);
    check32("coll_gnt_if", 32'(gnt_dm), 32'd0);
    goto(t + 10);
    if_req = 1'b0;

    // Starvation guard: both held, grant order dm x4, if, dm x4, if.
    step();
    t = cyc;
    if_addr = 32'h80; if_req = 1'b1;
    dm_addr = 32'h300; dm_we = 1'b1; dm_wdata = 32'h77; dm_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) begin
        push_iss_a(t + 1 + 5 * k, 32'h80, 1'b0, 32'h0);
        push_ack_a(t + 4 + 5 * k, 1'b0, 32'hFF7F_0080);
      end else begin
        push_iss_a(t + 1 + 5 * k, 32'h300, 1'b1, 32'h77);
        push_ack_a(t + 4 + 5 * k, 1'b1, 32'hFDFF_0200);
      end
    end
    goto(t + 50);
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;

    // Streaming fetch on the MEM_LAT=1 instance.
    step();
    t = cyc;
    b_if_addr = 32'h0; b_if_req = 1'b1;
    push_iss_b(t + 1, 32'h0);  push_ack_b(t + 3,  32'hFFFF_0000);
    push_iss_b(t + 5, 32'h4);  push_ack_b(t + 7,  32'hFFFB_0004);
    push_iss_b(t + 9, 32'h8);  push_ack_b(t + 11, 32'hFFF7_0008);
    goto(t + 4);
    b_if_addr = 32'h4;
    goto(t + 8);
    b_if_addr = 32'h8;
    goto(t + 12);
    b_if_req = 1'b0;

    repeat (6) step();
    @(negedge clk);
    check32("b_idle", 32'({b_busy, b_gnt_dm, b_dm_stall, b_if_stall}), 32'd0);
    check32("q_iss_a_left", 32'(q_iss_a.size()), 32'd0);
    check32("q_ack_a_left", 32'(q_ack_a.size()), 32'd0);
    check32("q_iss_b_left", 32'(q_iss_b.size()), 32'd0);
    check32("q_ack_b_left", 32'(q_ack_b.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
